// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: state encoding, default PC width
// and the sequential fetch increment.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FETCH    = 2'd1,
    S_REDIRECT = 2'd2,
    S_HALT     = 2'd3
  } pc_state_e;

  localparam int PC_W_DEF = 12;
  localparam int PC_INC   = 4;

endpackage

// File: rtl/pc_target_adder.sv
// Branch target adder: br_pc plus the low PC_W bits of the pre-shifted
// signed offset, wrapping modulo 2^PC_W. PC_W is expected to be below 64.
module pc_target_adder #(
  parameter int PC_W = 12
) (
  input  logic [PC_W-1:0] br_pc,
  input  logic [63:0]     br_offset,
  output logic [PC_W-1:0] target
);

  // The low PC_W bits of a 64-bit sum equal the PC_W-bit wrapped sum, so the
  // upper offset bits only ever affect bits that the cast discards.
  assign target = PC_W'({{(64-PC_W){1'b0}}, br_pc} + br_offset);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: issues fetch requests over a valid/ready
// handshake, applies resolved branches and supports a sticky halt.
// Optional feature macro: PC_SEQ_ALIGN_CHECK_EN -- a misaligned taken target
// raises err and halts instead of being rounded down to a word boundary.
//
// Handshake: fetch_valid/fetch_pc are offered each cycle; the request is
// consumed only on a cycle where fetch_valid && fetch_ready at the rising
// edge, and fetch_pc stays stable while fetch_valid=1 and fetch_ready=0.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            CLOCK,
  input  logic            RESET,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [PC_W-1:0] fetch_pc,
  input  logic            br_valid,
  input  logic [PC_W-1:0] br_pc,
  input  logic [63:0]     br_offset,
  input  logic            br_cond,
  input  logic            br_zero,
  input  logic            br_uncond,
  input  logic            stall,
  input  logic            halt,
  output logic            redirect,
  output logic            err,
  output pc_state_e       state
);

  pc_state_e       state_n;
  logic [PC_W-1:0] pc, pc_n;
  logic [PC_W-1:0] target;
  logic            redirect_n;
  logic            taken;
  logic            err_q, err_n;

  pc_target_adder #(.PC_W(PC_W)) u_target (
    .br_pc     (br_pc),
    .br_offset (br_offset),
    .target    (target)
  );

  assign taken       = br_valid && (br_uncond || (br_cond && br_zero));
  assign fetch_valid = (state == S_FETCH) && !stall;
  assign fetch_pc    = pc;

`ifdef PC_SEQ_ALIGN_CHECK_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Next-state, next-PC and redirect/err selection.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    redirect_n = 1'b0;
    err_n      = err_q;
    case (state)
      S_IDLE: state_n = S_FETCH;
      S_FETCH, S_REDIRECT: begin
        if (halt) begin
          state_n = S_HALT;
        end else if (taken) begin
`ifdef PC_SEQ_ALIGN_CHECK_EN
          if (target[1:0] != 2'b00) begin
            err_n   = 1'b1;
            state_n = S_HALT;
          end else begin
            pc_n       = target;
            redirect_n = 1'b1;
            state_n    = S_REDIRECT;
          end
`else
          pc_n       = target & ~PC_W'(3);
          redirect_n = 1'b1;
          state_n    = S_REDIRECT;
`endif
        end else if (state == S_REDIRECT) begin
          state_n = S_FETCH;
        end else if (fetch_valid && fetch_ready) begin
          pc_n = pc + PC_W'(PC_INC);
        end
      end
      default: state_n = S_HALT;
    endcase
  end

  // State, PC and status registers with synchronous reset.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      redirect <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      redirect <= redirect_n;
      err_q    <= err_n;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int W = 12;

  logic         CLOCK = 1'b0;
  logic         RESET;
  logic         fetch_valid;
  logic         fetch_ready;
  logic [W-1:0] fetch_pc;
  logic         br_valid;
  logic [W-1:0] br_pc;
  logic [63:0]  br_offset;
  logic         br_cond, br_zero, br_uncond;
  logic         stall, halt;
  logic         redirect, err;
  pc_state_e    state;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  pc_sequencer #(.PC_W(W), .RESET_PC('0)) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_pc    (fetch_pc),
    .br_valid    (br_valid),
    .br_pc       (br_pc),
    .br_offset   (br_offset),
    .br_cond     (br_cond),
    .br_zero     (br_zero),
    .br_uncond   (br_uncond),
    .stall       (stall),
    .halt        (halt),
    .redirect    (redirect),
    .err         (err),
    .state       (state)
  );

  // Clock
  always #5 CLOCK = ~CLOCK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle past the edge.
  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic set_br(input logic [W-1:0] pc, input logic [63:0] off,
                        input logic cond, input logic zero, input logic uncond);
    br_valid  = 1'b1;
    br_pc     = pc;
    br_offset = off;
    br_cond   = cond;
    br_zero   = zero;
    br_uncond = uncond;
  endtask

  task automatic clr_br();
    br_valid  = 1'b0;
    br_cond   = 1'b0;
    br_zero   = 1'b0;
    br_uncond = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; fetch_ready = 1'b0; stall = 1'b0; halt = 1'b0;
    br_pc = '0; br_offset = '0;
    clr_br();
    step(); step();

    // Reset state; this settled cycle is the single IDLE cycle.
    check_eq("rst_state", 64'(state), 64'(S_IDLE));
    check_eq("rst_pc", 64'(fetch_pc), 64'd0);
    check_eq("rst_fv", 64'(fetch_valid), 64'd0);
    check_eq("rst_redirect", 64'(redirect), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);

    // Sequential fetch with ready held high.
    RESET = 1'b0; fetch_ready = 1'b1;
    exp_q.push_back(12'd0); exp_q.push_back(12'd4); exp_q.push_back(12'd8);
    step();
    check_eq("idle_to_fetch", 64'(state), 64'(S_FETCH));
    check_eq("seq_fv", 64'(fetch_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check_eq("seq_pc", 64'(fetch_pc), 64'(exp_q.pop_front()));
      if (i < 2) step();
    end

    // Unconditional branch +8 overriding a handshake.
    set_br(12'd300, 64'd8, 1'b0, 1'b0, 1'b1);
    step();
    check_eq("br_fwd_state", 64'(state), 64'(S_REDIRECT));
    check_eq("br_fwd_redirect", 64'(redirect), 64'd1);
    check_eq("br_fwd_bubble", 64'(fetch_valid), 64'd0);
    check_eq("br_fwd_pc", 64'(fetch_pc), 64'd308);
    clr_br(); fetch_ready = 1'b0;
    step();
    check_eq("br_fwd_back", 64'(state), 64'(S_FETCH));
    check_eq("br_fwd_pulse_end", 64'(redirect), 64'd0);
    check_eq("br_fwd_pc2", 64'(fetch_pc), 64'd308);

    // Backward branch -8.
    set_br(12'd300, -64'sd8, 1'b0, 1'b0, 1'b1);
    step();
    check_eq("br_back_pc", 64'(fetch_pc), 64'd292);
    check_eq("br_back_redirect", 64'(redirect), 64'd1);
    clr_br();
    step();
    check_eq("br_back_state", 64'(state), 64'(S_FETCH));

    // Conditional branch not taken: normal +4.
    fetch_ready = 1'b1;
    set_br(12'd300, 64'd76, 1'b1, 1'b0, 1'b0);
    step();
    check_eq("nt_pc", 64'(fetch_pc), 64'd296);
    check_eq("nt_redirect", 64'(redirect), 64'd0);
    check_eq("nt_state", 64'(state), 64'(S_FETCH));

    // Conditional taken with stall and ready both high.
    set_br(12'd300, 64'd76, 1'b1, 1'b1, 1'b0);
    stall = 1'b1;
    #1;
    check_eq("stall_fv", 64'(fetch_valid), 64'd0);
    step();
    check_eq("ct_pc", 64'(fetch_pc), 64'd376);
    check_eq("ct_redirect", 64'(redirect), 64'd1);
    clr_br(); stall = 1'b0; fetch_ready = 1'b0;
    step();
    check_eq("ct_pc2", 64'(fetch_pc), 64'd376);

    // Move to 4092, hold under backpressure, then wrap.
    set_br(12'd4000, 64'd92, 1'b0, 1'b0, 1'b1);
    step();
    clr_br();
    step();
    for (int i = 0; i < 3; i++) begin
      check_eq("hold_pc", 64'(fetch_pc), 64'd4092);
      check_eq("hold_fv", 64'(fetch_valid), 64'd1);
      step();
    end
    fetch_ready = 1'b1;
    step();
    check_eq("wrap_pc", 64'(fetch_pc), 64'd0);
    fetch_ready = 1'b0;

    // Misaligned target.
    set_br(12'd300, 64'd7, 1'b0, 1'b0, 1'b1);
    step();
    clr_br();
`ifdef PC_SEQ_ALIGN_CHECK_EN
    check_eq("mis_state", 64'(state), 64'(S_HALT));
    check_eq("mis_err", 64'(err), 64'd1);
    check_eq("mis_fv", 64'(fetch_valid), 64'd0);
    check_eq("mis_pc", 64'(fetch_pc), 64'd0);
`else
    check_eq("mis_pc", 64'(fetch_pc), 64'd304);
    check_eq("mis_err", 64'(err), 64'd0);
    step();
    check_eq("mis_state", 64'(state), 64'(S_FETCH));
`endif

    // Reset during activity with ready high.
    RESET = 1'b1; fetch_ready = 1'b1;
    step();
    check_eq("rst2_state", 64'(state), 64'(S_IDLE));
    check_eq("rst2_pc", 64'(fetch_pc), 64'd0);
    check_eq("rst2_err", 64'(err), 64'd0);
    RESET = 1'b0; fetch_ready = 1'b0;
    step();

    // Halt during REDIRECT wins over a taken branch.
    set_br(12'd100, 64'd20, 1'b0, 1'b0, 1'b1);
    step();
    check_eq("h_redirect_state", 64'(state), 64'(S_REDIRECT));
    set_br(12'd200, 64'd8, 1'b0, 1'b0, 1'b1);
    halt = 1'b1;
    step();
    check_eq("h_state", 64'(state), 64'(S_HALT));
    check_eq("h_pc", 64'(fetch_pc), 64'd120);
    check_eq("h_redirect", 64'(redirect), 64'd0);
    clr_br(); halt = 1'b0; fetch_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("h_stay", 64'(state), 64'(S_HALT));
      check_eq("h_fv", 64'(fetch_valid), 64'd0);
      check_eq("h_hold_pc", 64'(fetch_pc), 64'd120);
    end
    RESET = 1'b1;
    step();
    check_eq("h_rst_state", 64'(state), 64'(S_IDLE));
    check_eq("h_rst_pc", 64'(fetch_pc), 64'd0);
    check_eq("h_rst_fv", 64'(fetch_valid), 64'd0);
    RESET = 1'b0;
    step();
    check_eq("h_rst_fetch", 64'(state), 64'(S_FETCH));
    check_eq("h_rst_fetch_pc", 64'(fetch_pc), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, default 12, SHALL set the program-counter width in bits.
REQ-002 Parameter RESET_PC, default 0, SHALL set the PC value loaded on reset.
REQ-003 Port CLOCK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port RESET  in  1  SHALL be the synchronous, active-high reset.
REQ-005 Port fetch_valid  out  1  SHALL flag that fetch_pc is a valid fetch request.
REQ-006 Port fetch_ready  in  1  SHALL flag that instruction memory accepts the request this cycle.
REQ-007 Port fetch_pc  out  PC_W  SHALL be the current PC.
REQ-008 Port br_valid  in  1  SHALL flag a branch resolution this cycle.
REQ-009 Port br_pc  in  PC_W  SHALL be the PC of the resolving branch.
REQ-010 Port br_offset  in  64  SHALL be the signed byte offset, already shifted left by 2.
REQ-011 Ports br_cond, br_zero, br_uncond  in  1 each  SHALL be the conditional-branch flag, ALU zero flag and unconditional-branch flag.
REQ-012 Port stall  in  1  SHALL request a fetch hold.
REQ-013 Port halt  in  1  SHALL request permanent stop until reset.
REQ-014 Port redirect  out  1  SHALL pulse one cycle when a taken branch updates the PC.
REQ-015 Port err  out  1  SHALL flag a misaligned branch target (see Configuration).

Function
REQ-016 States SHALL be IDLE, FETCH, REDIRECT, HALT.
REQ-017 IDLE SHALL last exactly one cycle after reset, with fetch_valid=0, then go to FETCH.
REQ-018 In FETCH, fetch_valid SHALL equal !stall.
REQ-019 In FETCH, fetch_valid&&fetch_ready SHALL set PC <= PC+4, modulo 2^PC_W.
REQ-020 While fetch_valid=1 and fetch_ready=0, fetch_pc SHALL be held stable.
REQ-021 Taken SHALL be br_valid && (br_uncond || (br_cond && br_zero)).
REQ-022 Target SHALL be br_pc + br_offset[PC_W-1:0], truncated to PC_W (two's-complement wrap).
REQ-023 On taken, in FETCH or REDIRECT: PC <= target, redirect=1 next cycle, state REDIRECT.
REQ-024 A taken branch SHALL override a same-cycle fetch handshake and stall.
REQ-025 REDIRECT SHALL hold fetch_valid=0 for one cycle, then go to FETCH.
REQ-026 Not-taken or br_valid=0 SHALL leave PC unaffected by the branch inputs.
REQ-027 halt=1 in any non-IDLE state SHALL move to HALT; halt has priority over a taken branch.
REQ-028 HALT SHALL drive fetch_valid=0 and hold PC, exited only by RESET.

Reset
REQ-029 RESET SHALL set PC=RESET_PC, state=IDLE, fetch_valid=0, redirect=0, err=0.
REQ-030 RESET SHALL abort any in-flight handshake or redirect; fetch_ready is ignored that cycle.

Configuration
REQ-031 With PC_SEQ_ALIGN_CHECK_EN defined, a taken target with bits [1:0]!=0 SHALL load no PC, set err=1 and enter HALT.
REQ-032 Without PC_SEQ_ALIGN_CHECK_EN, target bits [1:0] SHALL be forced to 00 and err SHALL be tied 0.

Structure
REQ-033 Package pc_seq_pkg SHALL hold the state encoding, default PC_W and the PC increment constant 4.
REQ-034 Target arithmetic SHALL sit in sub-module pc_target_adder (br_pc, br_offset -> target).

Verification
REQ-035 Reset, fetch_ready=1 held -> IDLE one cycle, then fetch_pc 0, 4, 8 on consecutive cycles.
REQ-036 PC=4092, handshake -> fetch_pc=0 (wrap); fetch_ready=0 for 3 cycles -> fetch_pc held 4092 with fetch_valid=1.
REQ-037 br_valid=1, br_pc=300, br_offset=8, br_uncond=1 -> redirect pulse, one bubble, fetch_pc=308; br_offset=-8 -> 292.
REQ-038 br_cond=1 with br_zero=0 -> PC continues +4; with br_zero=1, br_offset=76 and simultaneous stall/handshake -> fetch_pc=br_pc+76.
REQ-039 br_offset=7, taken -> macro defined: err=1, HALT, fetch_valid=0; macro undefined: fetch_pc=br_pc+4, err=0.
REQ-040 halt=1 then RESET mid-REDIRECT -> fetch_valid stays 0 until reset; after RESET, PC=RESET_PC, IDLE.
